// File: rtl/cam_masked.sv
`default_nettype none
// ============================================================================
// Module      : cam_masked
// Description : Masked content-addressable memory of 2**ADDR_WIDTH entries,
//               each a {cmd_id, proc_id} pair plus a valid bit. Entries are
//               written or deleted by address. Every entry is compared against
//               compare_data on every cycle, with separate cmd/proc compare
//               enables. A registered, priority-encoded result is returned one
//               cycle after the key is sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_masked #(
    parameter int    DATA_WIDTH  = 6,
    parameter int    ADDR_WIDTH  = 3,
    parameter string CAM_STYLE   = "BRAM",
    parameter int    SLICE_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_WIDTH-1:0]    write_addr,
    input  logic [DATA_WIDTH-1:0]    write_data,
    input  logic                     write_delete,
    input  logic                     write_enable,
    input  logic [1:0]               select_mask,
    input  logic [DATA_WIDTH-1:0]    compare_data,
    output logic                     write_busy,
    output logic [2**ADDR_WIDTH-1:0] match_many,
    output logic [2**ADDR_WIDTH-1:0] match_single,
    output logic [ADDR_WIDTH-1:0]    match_addr,
    output logic                     match,
    output logic                     setup
);

    localparam int c_DEPTH      = 2**ADDR_WIDTH;
    localparam int c_CMD_W      = 4;
    localparam int c_PROC_W     = DATA_WIDTH - c_CMD_W;
    localparam int c_NUM_SLICES = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH;
    localparam int c_PAD_W      = c_NUM_SLICES * SLICE_WIDTH;
    // SRL storage is cleared from the top entry down, BRAM from entry 0 up;
    // the sweep length and all externally visible timing are the same.
    localparam bit c_SWEEP_DOWN = (CAM_STYLE == "SRL");
    localparam logic [ADDR_WIDTH-1:0] c_LAST_STEP = {ADDR_WIDTH{1'b1}};

    // ST_COMMIT is the cycle the captured request lands in storage;
    // ST_RELEASE holds busy one more cycle so the new content is settled
    // before another request can be accepted.
    typedef enum logic [1:0] {
        ST_SETUP   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_COMMIT  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t                r_state_q,   w_state_d;
    logic [ADDR_WIDTH-1:0] r_sweep_q,   w_sweep_d;
    logic [ADDR_WIDTH-1:0] r_wr_addr_q, w_wr_addr_d;
    logic [DATA_WIDTH-1:0] r_wr_data_q, w_wr_data_d;
    logic                  r_wr_del_q,  w_wr_del_d;
    logic [DATA_WIDTH-1:0] r_entry_q [c_DEPTH];
    logic [DATA_WIDTH-1:0] w_entry_d [c_DEPTH];
    logic [c_DEPTH-1:0]    r_valid_q,   w_valid_d;
    logic                  r_busy_q,    w_busy_d;
    logic                  r_setup_q,   w_setup_d;
    logic [c_DEPTH-1:0]    r_many_q,    w_many_d;
    logic [c_DEPTH-1:0]    r_single_q,  w_single_d;
    logic [ADDR_WIDTH-1:0] r_addr_q,    w_addr_d;
    logic                  r_match_q,   w_match_d;
    logic [ADDR_WIDTH-1:0] w_sweep_idx;
    logic [DATA_WIDTH-1:0] w_key_mask;

    assign w_sweep_idx = c_SWEEP_DOWN ? ~r_sweep_q : r_sweep_q;

    // Sequencing of the setup sweep and of write/delete requests.
    always_comb begin
        w_state_d   = r_state_q;
        w_sweep_d   = r_sweep_q;
        w_wr_addr_d = r_wr_addr_q;
        w_wr_data_d = r_wr_data_q;
        w_wr_del_d  = r_wr_del_q;
        w_valid_d   = r_valid_q;
        w_entry_d   = r_entry_q;
        case (r_state_q)
            ST_SETUP: begin
                w_valid_d[w_sweep_idx] = 1'b0;
                w_sweep_d              = r_sweep_q + ADDR_WIDTH'(1);
                if (r_sweep_q == c_LAST_STEP) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (write_enable) begin
                    w_wr_addr_d = write_addr;
                    w_wr_data_d = write_data;
                    w_wr_del_d  = write_delete;
                    w_state_d   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_valid_d[r_wr_addr_q] = ~r_wr_del_q;
                if (!r_wr_del_q) begin
                    w_entry_d[r_wr_addr_q] = r_wr_data_q;
                end
                w_state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_SETUP;
            end
        endcase
        w_busy_d  = (w_state_d != ST_IDLE);
        w_setup_d = (w_state_d == ST_SETUP);
    end

    // Disabled fields are zeroed out of the difference so they always agree.
    assign w_key_mask = {{c_CMD_W{select_mask[1]}}, {c_PROC_W{select_mask[0]}}};

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_cmp
        logic [c_PAD_W-1:0] w_diff;
        logic               w_hit;

        assign w_diff = c_PAD_W'((r_entry_q[gi] ^ compare_data) & w_key_mask);

        // An entry hits only when every compare slice shows no difference.
        always_comb begin
            w_hit = 1'b1;
            for (int s = 0; s < c_NUM_SLICES; s++) begin
                if (w_diff[s*SLICE_WIDTH +: SLICE_WIDTH] != '0) begin
                    w_hit = 1'b0;
                end
            end
        end

        assign w_many_d[gi] = r_valid_q[gi] & w_hit & (|select_mask);
    end

    // Lowest matching index wins; scanning downward leaves the lowest last.
    always_comb begin
        w_single_d = '0;
        w_addr_d   = '0;
        for (int i = c_DEPTH - 1; i >= 0; i--) begin
            if (w_many_d[i]) begin
                w_single_d    = '0;
                w_single_d[i] = 1'b1;
                w_addr_d      = ADDR_WIDTH'(i);
            end
        end
        w_match_d = |w_many_d;
    end

    // Control, valid bits and registered match results.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= ST_SETUP;
            r_sweep_q   <= '0;
            r_wr_addr_q <= '0;
            r_wr_data_q <= '0;
            r_wr_del_q  <= 1'b0;
            r_valid_q   <= '0;
            r_busy_q    <= 1'b1;
            r_setup_q   <= 1'b1;
            r_many_q    <= '0;
            r_single_q  <= '0;
            r_addr_q    <= '0;
            r_match_q   <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_sweep_q   <= w_sweep_d;
            r_wr_addr_q <= w_wr_addr_d;
            r_wr_data_q <= w_wr_data_d;
            r_wr_del_q  <= w_wr_del_d;
            r_valid_q   <= w_valid_d;
            r_busy_q    <= w_busy_d;
            r_setup_q   <= w_setup_d;
            r_many_q    <= w_many_d;
            r_single_q  <= w_single_d;
            r_addr_q    <= w_addr_d;
            r_match_q   <= w_match_d;
        end
    end

    // Entry payload needs no reset: the valid bits gate every use of it.
    always_ff @(posedge clk) begin
        r_entry_q <= w_entry_d;
    end

    assign write_busy   = r_busy_q;
    assign setup        = r_setup_q;
    assign match_many   = r_many_q;
    assign match_single = r_single_q;
    assign match_addr   = r_addr_q;
    assign match        = r_match_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_masked.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_masked
// Description : Self-checking bench for cam_masked. A behavioural model of
//               the entry table predicts every registered output each cycle;
//               directed steps add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_masked;

    localparam int DW       = 6;
    localparam int AW       = 3;
    localparam int DEPTH    = 8;
    localparam int PROC_CNT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [AW-1:0]    write_addr = '0;
    logic [DW-1:0]    write_data = '0;
    logic             write_delete = 1'b0;
    logic             write_enable = 1'b0;
    logic [1:0]       select_mask = 2'b11;
    logic [DW-1:0]    compare_data = '0;
    logic             write_busy;
    logic [DEPTH-1:0] match_many;
    logic [DEPTH-1:0] match_single;
    logic [AW-1:0]    match_addr;
    logic             match;
    logic             setup;

    int n_checks = 0;
    int n_fails  = 0;

    cam_masked #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .CAM_STYLE  ("BRAM"),
        .SLICE_WIDTH(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .write_delete(write_delete),
        .write_enable(write_enable),
        .select_mask (select_mask),
        .compare_data(compare_data),
        .write_busy  (write_busy),
        .match_many  (match_many),
        .match_single(match_single),
        .match_addr  (match_addr),
        .match       (match),
        .setup       (setup)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_data  [DEPTH];
    bit               m_valid [DEPTH];
    int               setup_left = 0;
    int               busy_left  = 0;
    int               p_addr, p_data;
    bit               p_del;
    logic [DEPTH-1:0] e_many, e_single;
    logic [AW-1:0]    e_addr;
    logic             e_match, e_busy, e_setup;
    bit               model_live = 1'b0;

    function automatic logic [DEPTH-1:0] ref_many(input logic [1:0] m, input int key);
        logic [DEPTH-1:0] r;
        bit cmd_ok, proc_ok;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cmd_ok  = !m[1] || (m_data[i] / PROC_CNT == key / PROC_CNT);
            proc_ok = !m[0] || (m_data[i] % PROC_CNT == key % PROC_CNT);
            r[i]    = m_valid[i] && cmd_ok && proc_ok && (m != 2'b00);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
            setup_left = DEPTH;
            busy_left  = 0;
            e_many = '0; e_single = '0; e_addr = '0; e_match = 1'b0;
            model_live = 1'b1;
        end else begin
            int idx;
            e_many  = ref_many(select_mask, int'(compare_data));
            e_match = (e_many != '0);
            idx = 0;
            for (int i = 0; i < DEPTH; i++) begin
                if (e_many[i]) begin idx = i; break; end
            end
            e_addr   = e_match ? AW'(idx) : '0;
            e_single = e_match ? (DEPTH'(1) << idx) : '0;
            if (setup_left > 0) begin
                setup_left--;
            end else if (busy_left > 0) begin
                if (busy_left == 2) begin
                    m_valid[p_addr] = !p_del;
                    if (!p_del) m_data[p_addr] = p_data;
                end
                busy_left--;
            end else if (write_enable) begin
                p_addr = int'(write_addr);
                p_data = int'(write_data);
                p_del  = write_delete;
                busy_left = 2;
            end
        end
        e_setup = (setup_left > 0);
        e_busy  = (setup_left > 0) || (busy_left > 0);
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (model_live) begin
            check("model_match",  32'(match),        32'(e_match));
            check("model_many",   32'(match_many),   32'(e_many));
            check("model_single", 32'(match_single), 32'(e_single));
            check("model_addr",   32'(match_addr),   32'(e_addr));
            check("model_busy",   32'(write_busy),   32'(e_busy));
            check("model_setup",  32'(setup),        32'(e_setup));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_idle();
        int k = 0;
        while (write_busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("busy_timeout", 32'(write_busy), 32'd0);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic del);
        write_addr   = a;
        write_data   = d;
        write_delete = del;
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        write_delete = 1'b0;
        wait_idle();
    endtask

    task automatic cmp(input logic [1:0] m, input logic [DW-1:0] k);
        select_mask  = m;
        compare_data = k;
        @(negedge clk);
    endtask

    task automatic count_setup(input string name);
        int cnt = 0;
        while (setup && cnt < 20) begin
            check({name, "_nomatch"}, 32'(match), 32'd0);
            cnt++;
            @(negedge clk);
        end
        check({name, "_len"}, 32'(cnt), 32'd8);
        check({name, "_busy_end"}, 32'(write_busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        // Setup sweep with an all-zero key
        rst = 1'b0;
        check("reset_setup", 32'(setup), 32'd1);
        check("reset_busy",  32'(write_busy), 32'd1);
        check("reset_match", 32'(match), 32'd0);
        count_setup("setup");

        // Full match on {1,2} at address 2
        do_write(3'd2, {4'd1, 2'd2}, 1'b0);
        cmp(2'b11, {4'd1, 2'd2});
        check("full_match",  32'(match),        32'd1);
        check("full_many",   32'(match_many),   32'h04);
        check("full_single", 32'(match_single), 32'h04);
        check("full_addr",   32'(match_addr),   32'd2);

        // Per-field masking
        cmp(2'b01, {4'd1, 2'd3});
        check("mask01_miss", 32'(match), 32'd0);
        cmp(2'b01, {4'd11, 2'd2});
        check("mask01_hit",  32'(match), 32'd1);
        check("mask01_addr", 32'(match_addr), 32'd2);
        cmp(2'b10, {4'd1, 2'd0});
        check("mask10_hit",  32'(match), 32'd1);
        cmp(2'b00, {4'd1, 2'd2});
        check("mask00_miss", 32'(match), 32'd0);
        check("mask00_many", 32'(match_many), 32'd0);

        // Delete
        do_write(3'd2, 6'd0, 1'b1);
        cmp(2'b11, {4'd1, 2'd2});
        check("del_miss11", 32'(match), 32'd0);
        check("del_addr",   32'(match_addr), 32'd0);
        cmp(2'b01, {4'd11, 2'd2});
        check("del_miss01", 32'(match), 32'd0);

        // Priority among two matching entries
        do_write(3'd5, {4'd1, 2'd2}, 1'b0);
        do_write(3'd3, {4'd1, 2'd2}, 1'b0);
        cmp(2'b11, {4'd1, 2'd2});
        check("prio_many",   32'(match_many),   32'h28);
        check("prio_single", 32'(match_single), 32'h08);
        check("prio_addr",   32'(match_addr),   32'd3);

        // Overwrite entry 3 while the key keeps looking for {1,2}
        write_addr   = 3'd3;
        write_data   = {4'd7, 2'd3};
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        check("ovw_old_e0", 32'(match_addr), 32'd3);
        @(negedge clk);
        check("ovw_old_e1", 32'(match_addr), 32'd3);
        check("ovw_busy",   32'(write_busy), 32'd1);
        @(negedge clk);
        check("ovw_new_addr",   32'(match_addr),   32'd5);
        check("ovw_new_many",   32'(match_many),   32'h20);
        check("ovw_new_single", 32'(match_single), 32'h20);
        check("ovw_idle",       32'(write_busy),   32'd0);
        cmp(2'b11, {4'd7, 2'd3});
        check("ovw_val_addr", 32'(match_addr), 32'd3);
        check("ovw_val_many", 32'(match_many), 32'h08);

        // Request while busy is dropped
        write_addr   = 3'd6;
        write_data   = {4'd2, 2'd0};
        write_enable = 1'b1;
        @(negedge clk);
        check("busy_second", 32'(write_busy), 32'd1);
        write_addr = 3'd7;
        write_data = {4'd9, 2'd1};
        @(negedge clk);
        write_enable = 1'b0;
        wait_idle();
        cmp(2'b11, {4'd9, 2'd1});
        check("busy_dropped", 32'(match), 32'd0);
        cmp(2'b11, {4'd2, 2'd0});
        check("busy_first_hit",  32'(match), 32'd1);
        check("busy_first_addr", 32'(match_addr), 32'd6);

        // Reset while a write is in flight
        write_addr   = 3'd4;
        write_data   = {4'd5, 2'd1};
        write_enable = 1'b1;
        @(negedge clk);
        write_enable = 1'b0;
        check("rstw_busy", 32'(write_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstw_setup", 32'(setup), 32'd1);
        check("rstw_match", 32'(match), 32'd0);
        count_setup("resetup");
        cmp(2'b11, {4'd5, 2'd1});
        check("rstw_aborted", 32'(match), 32'd0);
        cmp(2'b11, {4'd1, 2'd2});
        check("rstw_clear5", 32'(match), 32'd0);
        cmp(2'b10, {4'd2, 2'd0});
        check("rstw_clear6", 32'(match), 32'd0);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
